// File: rtl/id_ex_operand_stage_pkg.sv
// Shared types and constants for the ID/EX operand stage: widths, ALU opcodes,
// the control bundle with its bubble value, and the register-match helper.
package id_ex_operand_stage_pkg;

    localparam int DATA_W  = 32;
    localparam int REG_AW  = 5;
    localparam int ALU_W   = 4;
    localparam int SHAMT_W = 5;

    typedef enum logic [ALU_W-1:0] {
        ALU_ADD      = 4'd0,
        ALU_SUB      = 4'd1,
        ALU_AND      = 4'd2,
        ALU_OR       = 4'd3,
        ALU_SHFT_L   = 4'd4,
        ALU_SHFT_R_L = 4'd5,
        ALU_SHFT_R_A = 4'd6,
        ALU_GREATER  = 4'd7,
        ALU_LESS     = 4'd8,
        ALU_NOR      = 4'd9
    } alu_op_e;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '{reg_write: 1'b0, mem_read: 1'b0,
                                      mem_write: 1'b0, mem_to_reg: 1'b0};

    // A writer hits a source only when it writes and targets a nonzero register.
    function automatic logic reg_hit(input logic              we,
                                     input logic [REG_AW-1:0] wr_idx,
                                     input logic [REG_AW-1:0] src_idx);
        return we && (wr_idx != {REG_AW{1'b0}}) && (wr_idx == src_idx);
    endfunction

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// Decode-side, writeback-side and EX-side signals of the ID/EX operand stage.
// master = pipeline environment, slave = the operand stage.
interface id_ex_operand_stage_if;
    import id_ex_operand_stage_pkg::*;

    logic              flush;
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_rd;
    logic [DATA_W-1:0] id_rs_data;
    logic [DATA_W-1:0] id_rt_data;
    logic [DATA_W-1:0] id_imm;
    logic [SHAMT_W-1:0] id_shamt;
    logic [ALU_W-1:0]  id_alu_ctrl;
    logic              id_alu_src;
    logic              id_reg_dst;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              id_mem_write;
    logic              id_mem_to_reg;
    logic              exmem_reg_write;
    logic [REG_AW-1:0] exmem_rd;
    logic [DATA_W-1:0] exmem_result;
    logic              memwb_reg_write;
    logic [REG_AW-1:0] memwb_rd;
    logic [DATA_W-1:0] memwb_result;
    logic              stall;
    logic              ex_valid;
    logic [DATA_W-1:0] ex_data1;
    logic [DATA_W-1:0] ex_data2;
    logic [DATA_W-1:0] ex_store_data;
    logic [ALU_W-1:0]  ex_alu_ctrl;
    logic [SHAMT_W-1:0] ex_shamt;
    logic [REG_AW-1:0] ex_dest;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic              ex_mem_to_reg;

    modport master (
        output flush, id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm,
               id_shamt, id_alu_ctrl, id_alu_src, id_reg_dst, id_reg_write, id_mem_read,
               id_mem_write, id_mem_to_reg, exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_result,
        input  stall, ex_valid, ex_data1, ex_data2, ex_store_data, ex_alu_ctrl, ex_shamt,
               ex_dest, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg
    );

    modport slave (
        input  flush, id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm,
               id_shamt, id_alu_ctrl, id_alu_src, id_reg_dst, id_reg_write, id_mem_read,
               id_mem_write, id_mem_to_reg, exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_result,
        output stall, ex_valid, ex_data1, ex_data2, ex_store_data, ex_alu_ctrl, ex_shamt,
               ex_dest, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg
    );

endinterface

// File: rtl/id_ex_fwd_mux.sv
// Per-operand forward select: EX/MEM beats MEM/WB, register 0 never forwards.
// With fwd_en_i tied low the operand is always the register-file value.
module id_ex_fwd_mux
    import id_ex_operand_stage_pkg::*;
(
    input  logic              fwd_en_i,
    input  logic [REG_AW-1:0] src_i,
    input  logic [DATA_W-1:0] rf_data_i,
    input  logic              exmem_reg_write_i,
    input  logic [REG_AW-1:0] exmem_rd_i,
    input  logic [DATA_W-1:0] exmem_result_i,
    input  logic              memwb_reg_write_i,
    input  logic [REG_AW-1:0] memwb_rd_i,
    input  logic [DATA_W-1:0] memwb_result_i,
    output logic [DATA_W-1:0] data_o
);

    // Priority select of the youngest in-flight result for this source.
    always_comb begin
        data_o = rf_data_i;
        if (fwd_en_i && reg_hit(exmem_reg_write_i, exmem_rd_i, src_i)) begin
            data_o = exmem_result_i;
        end else if (fwd_en_i && reg_hit(memwb_reg_write_i, memwb_rd_i, src_i)) begin
            data_o = memwb_result_i;
        end else begin
            data_o = rf_data_i;
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with hazard resolution. Define ID_EX_FWD_EN to forward
// from EX/MEM and MEM/WB; otherwise any in-flight writer of a source stalls decode.
module id_ex_operand_stage
    import id_ex_operand_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    id_ex_operand_stage_if.slave bus
);

`ifdef ID_EX_FWD_EN
    localparam logic FWD_ON = 1'b1;
`else
    localparam logic FWD_ON = 1'b0;
`endif

    logic               uses_rt_s;
    logic               load_use_s;
    logic               rs_busy_s;
    logic               rt_busy_s;
    logic               raw_wait_s;
    logic               stall_s;
    logic               bubble_s;
    logic [DATA_W-1:0]  fwd_rs_s;
    logic [DATA_W-1:0]  fwd_rt_s;
    ctrl_t              id_ctrl_s;

    logic               valid_q, valid_d;
    ctrl_t              ctrl_q, ctrl_d;
    logic [REG_AW-1:0]  dest_q, dest_d;
    logic [DATA_W-1:0]  data1_q, data1_d;
    logic [DATA_W-1:0]  data2_q, data2_d;
    logic [DATA_W-1:0]  store_q, store_d;
    logic [ALU_W-1:0]   alu_q, alu_d;
    logic [SHAMT_W-1:0] shamt_q, shamt_d;

    assign id_ctrl_s = '{reg_write: bus.id_reg_write, mem_read: bus.id_mem_read,
                         mem_write: bus.id_mem_write, mem_to_reg: bus.id_mem_to_reg};

    id_ex_fwd_mux u_fwd_rs (
        .fwd_en_i          (FWD_ON),
        .src_i             (bus.id_rs),
        .rf_data_i         (bus.id_rs_data),
        .exmem_reg_write_i (bus.exmem_reg_write),
        .exmem_rd_i        (bus.exmem_rd),
        .exmem_result_i    (bus.exmem_result),
        .memwb_reg_write_i (bus.memwb_reg_write),
        .memwb_rd_i        (bus.memwb_rd),
        .memwb_result_i    (bus.memwb_result),
        .data_o            (fwd_rs_s)
    );

    id_ex_fwd_mux u_fwd_rt (
        .fwd_en_i          (FWD_ON),
        .src_i             (bus.id_rt),
        .rf_data_i         (bus.id_rt_data),
        .exmem_reg_write_i (bus.exmem_reg_write),
        .exmem_rd_i        (bus.exmem_rd),
        .exmem_result_i    (bus.exmem_result),
        .memwb_reg_write_i (bus.memwb_reg_write),
        .memwb_rd_i        (bus.memwb_rd),
        .memwb_result_i    (bus.memwb_result),
        .data_o            (fwd_rt_s)
    );

    // Hazard detection: load-use always; any pending writer only without forwarding.
    always_comb begin
        uses_rt_s  = bus.id_mem_write | ~bus.id_alu_src;
        load_use_s = valid_q & ctrl_q.mem_read & (dest_q != {REG_AW{1'b0}}) & bus.id_valid &
                     ((dest_q == bus.id_rs) | (uses_rt_s & (dest_q == bus.id_rt)));
        rs_busy_s  = reg_hit(valid_q & ctrl_q.reg_write, dest_q, bus.id_rs) |
                     reg_hit(bus.exmem_reg_write, bus.exmem_rd, bus.id_rs) |
                     reg_hit(bus.memwb_reg_write, bus.memwb_rd, bus.id_rs);
        rt_busy_s  = reg_hit(valid_q & ctrl_q.reg_write, dest_q, bus.id_rt) |
                     reg_hit(bus.exmem_reg_write, bus.exmem_rd, bus.id_rt) |
                     reg_hit(bus.memwb_reg_write, bus.memwb_rd, bus.id_rt);
        if (FWD_ON) begin
            raw_wait_s = 1'b0;
        end else begin
            raw_wait_s = bus.id_valid & (rs_busy_s | (uses_rt_s & rt_busy_s));
        end
        stall_s  = load_use_s | raw_wait_s;
        bubble_s = bus.flush | stall_s | ~bus.id_valid;
    end

    // Next-state: a bubble clears valid/control/dest and holds the data fields.
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        dest_d  = dest_q;
        data1_d = data1_q;
        data2_d = data2_q;
        store_d = store_q;
        alu_d   = alu_q;
        shamt_d = shamt_q;
        if (bubble_s) begin
            valid_d = 1'b0;
            ctrl_d  = CTRL_BUBBLE;
            dest_d  = {REG_AW{1'b0}};
        end else begin
            valid_d = 1'b1;
            ctrl_d  = id_ctrl_s;
            dest_d  = bus.id_reg_dst ? bus.id_rd : bus.id_rt;
            data1_d = fwd_rs_s;
            data2_d = bus.id_alu_src ? bus.id_imm : fwd_rt_s;
            store_d = fwd_rt_s;
            alu_d   = bus.id_alu_ctrl;
            shamt_d = bus.id_shamt;
        end
    end

    // ID/EX pipeline register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= CTRL_BUBBLE;
            dest_q  <= {REG_AW{1'b0}};
            data1_q <= {DATA_W{1'b0}};
            data2_q <= {DATA_W{1'b0}};
            store_q <= {DATA_W{1'b0}};
            alu_q   <= ALU_ADD;
            shamt_q <= {SHAMT_W{1'b0}};
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            dest_q  <= dest_d;
            data1_q <= data1_d;
            data2_q <= data2_d;
            store_q <= store_d;
            alu_q   <= alu_d;
            shamt_q <= shamt_d;
        end
    end

    assign bus.stall         = stall_s;
    assign bus.ex_valid      = valid_q;
    assign bus.ex_data1      = data1_q;
    assign bus.ex_data2      = data2_q;
    assign bus.ex_store_data = store_q;
    assign bus.ex_alu_ctrl   = alu_q;
    assign bus.ex_shamt      = shamt_q;
    assign bus.ex_dest       = dest_q;
    assign bus.ex_reg_write  = ctrl_q.reg_write;
    assign bus.ex_mem_read   = ctrl_q.mem_read;
    assign bus.ex_mem_write  = ctrl_q.mem_write;
    assign bus.ex_mem_to_reg = ctrl_q.mem_to_reg;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: a pipeline-level reference model pushes
// expected stall/EX state per issued cycle, a monitor pops and compares after each edge.
module tb_id_ex_operand_stage;
    import id_ex_operand_stage_pkg::*;

    typedef struct {
        logic        stall;
        logic        valid;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] st;
        logic [3:0]  alu;
        logic [4:0]  sh;
        logic [4:0]  dest;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        mtr;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    // Reference model of the instruction currently held in EX.
    logic        m_valid, m_rw, m_mr, m_mw, m_mtr, last_stall;
    logic [4:0]  m_dest, m_sh;
    logic [3:0]  m_alu;
    logic [31:0] m_d1, m_d2, m_st;

    id_ex_operand_stage_if bus();

    id_ex_operand_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_rw = 1'b0; m_mr = 1'b0; m_mw = 1'b0; m_mtr = 1'b0;
        m_dest = 5'd0; m_sh = 5'd0; m_alu = 4'd0;
        m_d1 = 32'd0; m_d2 = 32'd0; m_st = 32'd0;
        last_stall = 1'b0;
    endtask

    function automatic logic [31:0] model_fwd(input logic [4:0] s, input logic [31:0] rf);
`ifdef ID_EX_FWD_EN
        if (s != 5'd0 && bus.exmem_reg_write && bus.exmem_rd == s) return bus.exmem_result;
        if (s != 5'd0 && bus.memwb_reg_write && bus.memwb_rd == s) return bus.memwb_result;
`endif
        return rf;
    endfunction

    // Derive expected stall and next EX contents from the current ID/WB inputs.
    task automatic model_push();
        exp_t        e;
        logic        urt, hz;
        logic [4:0]  writers[$];
        logic [31:0] a, b;
        urt = bus.id_mem_write | ~bus.id_alu_src;
        hz  = 1'b0;
        if (m_valid && m_mr && m_dest != 5'd0 && bus.id_valid &&
            (m_dest == bus.id_rs || (urt && m_dest == bus.id_rt))) hz = 1'b1;
`ifndef ID_EX_FWD_EN
        if (m_valid && m_rw) writers.push_back(m_dest);
        if (bus.exmem_reg_write) writers.push_back(bus.exmem_rd);
        if (bus.memwb_reg_write) writers.push_back(bus.memwb_rd);
        foreach (writers[i])
            if (bus.id_valid && writers[i] != 5'd0 &&
                (writers[i] == bus.id_rs || (urt && writers[i] == bus.id_rt))) hz = 1'b1;
`endif
        a = model_fwd(bus.id_rs, bus.id_rs_data);
        b = model_fwd(bus.id_rt, bus.id_rt_data);
        if (bus.flush || hz || !bus.id_valid) begin
            m_valid = 1'b0; m_rw = 1'b0; m_mr = 1'b0; m_mw = 1'b0; m_mtr = 1'b0;
            m_dest = 5'd0;
        end else begin
            m_valid = 1'b1;
            m_rw = bus.id_reg_write; m_mr = bus.id_mem_read;
            m_mw = bus.id_mem_write; m_mtr = bus.id_mem_to_reg;
            m_dest = bus.id_reg_dst ? bus.id_rd : bus.id_rt;
            m_d1 = a;
            m_d2 = bus.id_alu_src ? bus.id_imm : b;
            m_st = b;
            m_alu = bus.id_alu_ctrl;
            m_sh = bus.id_shamt;
        end
        e.stall = hz; e.valid = m_valid; e.d1 = m_d1; e.d2 = m_d2; e.st = m_st;
        e.alu = m_alu; e.sh = m_sh; e.dest = m_dest;
        e.rw = m_rw; e.mr = m_mr; e.mw = m_mw; e.mtr = m_mtr;
        exp_q.push_back(e);
        last_stall = hz;
    endtask

    // Called just after a negedge with inputs set; returns at the next negedge.
    task automatic issue();
        #1;
        model_push();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.flush = 1'b0; bus.id_valid = 1'b0;
        bus.id_rs = 5'd0; bus.id_rt = 5'd0; bus.id_rd = 5'd0;
        bus.id_rs_data = 32'd0; bus.id_rt_data = 32'd0; bus.id_imm = 32'd0;
        bus.id_shamt = 5'd0; bus.id_alu_ctrl = 4'd0; bus.id_alu_src = 1'b0;
        bus.id_reg_dst = 1'b0; bus.id_reg_write = 1'b0; bus.id_mem_read = 1'b0;
        bus.id_mem_write = 1'b0; bus.id_mem_to_reg = 1'b0;
        bus.exmem_reg_write = 1'b0; bus.exmem_rd = 5'd0; bus.exmem_result = 32'd0;
        bus.memwb_reg_write = 1'b0; bus.memwb_rd = 5'd0; bus.memwb_result = 32'd0;
    endtask

    task automatic set_lw(input logic [4:0] rs, input logic [4:0] dst);
        clear_inputs();
        bus.id_valid = 1'b1; bus.id_rs = rs; bus.id_rt = dst; bus.id_alu_src = 1'b1;
        bus.id_imm = 32'h0000_0010; bus.id_rs_data = 32'h0000_1000;
        bus.id_reg_write = 1'b1; bus.id_mem_read = 1'b1; bus.id_mem_to_reg = 1'b1;
    endtask

    task automatic set_alu(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        clear_inputs();
        bus.id_valid = 1'b1; bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd;
        bus.id_reg_dst = 1'b1; bus.id_reg_write = 1'b1; bus.id_alu_ctrl = 4'd1;
        bus.id_rs_data = 32'h0000_0011; bus.id_rt_data = 32'h0000_0022;
    endtask

    task automatic rand_inputs(input logic hold_id);
        if (!hold_id) begin
            bus.id_valid = ($urandom_range(0, 7) != 0);
            bus.id_rs = 5'($urandom_range(0, 7));
            bus.id_rt = 5'($urandom_range(0, 7));
            bus.id_rd = 5'($urandom_range(0, 7));
            bus.id_rs_data = $urandom; bus.id_rt_data = $urandom; bus.id_imm = $urandom;
            bus.id_shamt = 5'($urandom_range(0, 31));
            bus.id_alu_ctrl = 4'($urandom_range(0, 9));
            bus.id_alu_src = 1'($urandom_range(0, 1));
            bus.id_reg_dst = 1'($urandom_range(0, 1));
            bus.id_reg_write = 1'($urandom_range(0, 1));
            bus.id_mem_read = ($urandom_range(0, 2) == 0);
            bus.id_mem_write = ($urandom_range(0, 3) == 0);
            bus.id_mem_to_reg = 1'($urandom_range(0, 1));
        end
        bus.flush = ($urandom_range(0, 9) == 0);
        bus.exmem_reg_write = ($urandom_range(0, 2) == 0);
        bus.exmem_rd = 5'($urandom_range(0, 7));
        bus.exmem_result = $urandom;
        bus.memwb_reg_write = ($urandom_range(0, 2) == 0);
        bus.memwb_rd = 5'($urandom_range(0, 7));
        bus.memwb_result = $urandom;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(bus.ex_valid), 32'd0);
        chk({tag, "_data1"}, bus.ex_data1, 32'd0);
        chk({tag, "_data2"}, bus.ex_data2, 32'd0);
        chk({tag, "_store"}, bus.ex_store_data, 32'd0);
        chk({tag, "_alu"}, 32'(bus.ex_alu_ctrl), 32'(ALU_ADD));
        chk({tag, "_shamt"}, 32'(bus.ex_shamt), 32'd0);
        chk({tag, "_dest"}, 32'(bus.ex_dest), 32'd0);
        chk({tag, "_ctrl"}, 32'({bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
                                 bus.ex_mem_to_reg}), 32'd0);
        chk({tag, "_stall"}, 32'(bus.stall), 32'd0);
    endtask

    // Monitor: stall sampled mid-cycle, EX outputs just after the edge.
    initial begin : monitor
        exp_t e;
        logic st;
        forever begin
            @(negedge clk);
            #3;
            st = bus.stall;
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("stall", 32'(st), 32'(e.stall));
                chk("ex_valid", 32'(bus.ex_valid), 32'(e.valid));
                chk("ex_data1", bus.ex_data1, e.d1);
                chk("ex_data2", bus.ex_data2, e.d2);
                chk("ex_store_data", bus.ex_store_data, e.st);
                chk("ex_alu_ctrl", 32'(bus.ex_alu_ctrl), 32'(e.alu));
                chk("ex_shamt", 32'(bus.ex_shamt), 32'(e.sh));
                chk("ex_dest", 32'(bus.ex_dest), 32'(e.dest));
                chk("ex_ctrl", 32'({bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
                                    bus.ex_mem_to_reg}), 32'({e.rw, e.mr, e.mw, e.mtr}));
            end
        end
    end

    initial begin : stimulus
        clear_inputs();
        model_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk_all_zero("por");
        @(negedge clk);
        reset = 1'b0;

        // EX/MEM forward of r3.
        set_alu(5'd3, 5'd4, 5'd10);
        bus.exmem_reg_write = 1'b1; bus.exmem_rd = 5'd3; bus.exmem_result = 32'h0000_00AA;
        issue();
        // Both stages match r5: EX/MEM must win.
        set_alu(5'd5, 5'd6, 5'd11);
        bus.exmem_reg_write = 1'b1; bus.exmem_rd = 5'd5; bus.exmem_result = 32'h0000_0001;
        bus.memwb_reg_write = 1'b1; bus.memwb_rd = 5'd5; bus.memwb_result = 32'h0000_0002;
        issue();
        // r0 source with every stage targeting r0: register-file value.
        set_alu(5'd0, 5'd0, 5'd12);
        bus.exmem_reg_write = 1'b1; bus.exmem_rd = 5'd0; bus.exmem_result = 32'h0000_0001;
        bus.memwb_reg_write = 1'b1; bus.memwb_rd = 5'd0; bus.memwb_result = 32'h0000_0002;
        issue();

        // Load-use on r7: one bubble, then the dependent loads with MEM/WB data.
        set_lw(5'd1, 5'd7);
        issue();
        set_alu(5'd7, 5'd2, 5'd13);
        issue();
        bus.memwb_reg_write = 1'b1; bus.memwb_rd = 5'd7; bus.memwb_result = 32'h0000_0077;
        issue();
        bus.memwb_reg_write = 1'b0; bus.id_rs_data = 32'h0000_0077;
        issue();

        // Immediate operand: rt matches the load dest but is not read.
        set_lw(5'd1, 5'd7);
        issue();
        set_alu(5'd2, 5'd7, 5'd14);
        bus.id_alu_src = 1'b1; bus.id_imm = 32'hFFFF_FFFC;
        issue();

        // Flush coinciding with a load-use stall.
        set_lw(5'd1, 5'd8);
        issue();
        set_alu(5'd8, 5'd1, 5'd15);
        bus.id_mem_write = 1'b1; bus.flush = 1'b1;
        issue();
        clear_inputs();
        issue();

        // Writer in MEM/WB, flushed first, then released when the write retires.
        set_alu(5'd9, 5'd1, 5'd16);
        bus.memwb_reg_write = 1'b1; bus.memwb_rd = 5'd9; bus.memwb_result = 32'h0000_0999;
        bus.flush = 1'b1;
        issue();
        bus.flush = 1'b0;
        issue();
        bus.memwb_reg_write = 1'b0; bus.id_rs_data = 32'h0000_0999;
        issue();

        // Asynchronous reset in the middle of a load-use stall.
        set_lw(5'd1, 5'd7);
        issue();
        set_alu(5'd7, 5'd2, 5'd13);
        #1;
        chk("pre_reset_stall", 32'(bus.stall), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk_all_zero("async_reset");
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        clear_inputs();

        for (int i = 0; i < 400; i++) begin
            rand_inputs(last_stall);
            issue();
        end
        clear_inputs();

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
